// File: rtl/gpio_bank_if.sv
// Register bus between the SoC address decoder and the GPIO bank:
// word address, write strobe, write data and combinational read data.
interface gpio_bank_if #(
    parameter int WIDTH = 32,
    parameter int NCH   = 2,
    localparam int AW   = $clog2(4 * NCH)
);
    logic [AW-1:0]    a;
    logic             we;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] rd;

    modport master (output a, we, wd, input rd);
    modport slave  (input a, we, wd, output rd);
endinterface

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: NCH channels of synchronised inputs with rising-edge
// detection, output registers, per-bit interrupt enables and sticky W1C status.
module gpio_bank #(
    parameter int WIDTH       = 32,
    parameter int NCH         = 2,
    parameter int SYNC_STAGES = 2,
    localparam int AW         = $clog2(4 * NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    gpio_bank_if.slave           bus,
    input  logic [NCH*WIDTH-1:0] gpi,
    output logic [NCH*WIDTH-1:0] gpo,
    output logic                 irq
);

    logic [SYNC_STAGES-1:0][NCH*WIDTH-1:0] sync_r;
    logic [NCH*WIDTH-1:0]                  prev_r;

    logic [NCH-1:0][WIDTH-1:0] gpi_s;
    logic [NCH-1:0][WIDTH-1:0] rise_s;
    logic [NCH-1:0][WIDTH-1:0] clr_s;
    logic [NCH-1:0][WIDTH-1:0] gpo_r;
    logic [NCH-1:0][WIDTH-1:0] en_r;
    logic [NCH-1:0][WIDTH-1:0] status_r;
    logic [NCH-1:0][WIDTH-1:0] gpo_nxt_s;
    logic [NCH-1:0][WIDTH-1:0] en_nxt_s;
    logic [NCH-1:0][WIDTH-1:0] status_nxt_s;
    logic [WIDTH-1:0]          rd_s;

    assign gpi_s  = sync_r[SYNC_STAGES-1];
    assign rise_s = sync_r[SYNC_STAGES-1] & ~prev_r;

    // Input synchroniser chain plus the previous-value flop for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= '0;
            prev_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], gpi};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // Register write decode; a new enabled edge outranks a same-cycle W1C clear
    always_comb begin
        gpo_nxt_s    = gpo_r;
        en_nxt_s     = en_r;
        clr_s        = '0;
        status_nxt_s = status_r;
        for (int c = 0; c < NCH; c++) begin
            if (bus.we && (bus.a == AW'(4 * c + 1))) begin
                gpo_nxt_s[c] = bus.wd;
            end else begin
                gpo_nxt_s[c] = gpo_r[c];
            end
            if (bus.we && (bus.a == AW'(4 * c + 2))) begin
                en_nxt_s[c] = bus.wd;
            end else begin
                en_nxt_s[c] = en_r[c];
            end
            if (bus.we && (bus.a == AW'(4 * c + 3))) begin
                clr_s[c] = bus.wd;
            end else begin
                clr_s[c] = '0;
            end
            status_nxt_s[c] = (status_r[c] & ~clr_s[c]) | (rise_s[c] & en_r[c]);
        end
    end

    // Software-visible register state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpo_r    <= '0;
            en_r     <= '0;
            status_r <= '0;
        end else begin
            gpo_r    <= gpo_nxt_s;
            en_r     <= en_nxt_s;
            status_r <= status_nxt_s;
        end
    end

    // Read mux; unmapped indices fall through to zero
    always_comb begin
        rd_s = '0;
        for (int c = 0; c < NCH; c++) begin
            rd_s = rd_s
                 | ({WIDTH{bus.a == AW'(4 * c + 0)}} & gpi_s[c])
                 | ({WIDTH{bus.a == AW'(4 * c + 1)}} & gpo_r[c])
                 | ({WIDTH{bus.a == AW'(4 * c + 2)}} & en_r[c])
                 | ({WIDTH{bus.a == AW'(4 * c + 3)}} & status_r[c]);
        end
    end

    assign bus.rd = rd_s;
    assign gpo    = gpo_r;
    assign irq    = |(status_r & en_r);

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank (3 channels so unmapped indices are reachable).
module tb_gpio_bank;
    localparam int WIDTH = 32;
    localparam int NCH   = 3;
    localparam int AW    = $clog2(4 * NCH);
    localparam int W     = NCH * WIDTH;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] gpi;
    logic [W-1:0] gpo;
    logic         irq;

    gpio_bank_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

    gpio_bank #(.WIDTH(WIDTH), .NCH(NCH), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .bus(bus), .gpi(gpi), .gpo(gpo), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [AW-1:0] a;
        logic          we;
        logic [31:0]   wd;
        logic [31:0]   rd;
        logic [W-1:0]  gpo;
    } vec_t;
    vec_t vecs[13];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic expect_val(input string name, input logic [W-1:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic check_next(input logic [W-1:0] act);
        sb_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            $display("FAIL scoreboard_empty: got %h expected an entry", act);
        end else begin
            e = sb_q.pop_front();
            if (act === e.exp) n_pass++;
            else $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [31:0] data);
        bus.a  = AW'(addr);
        bus.we = 1'b1;
        bus.wd = data;
        tick();
        bus.we = 1'b0;
    endtask

    task automatic read_chk(input int addr, input logic [31:0] exp, input string name);
        bus.a = AW'(addr);
        expect_val(name, W'(exp));
        #1;
        check_next(W'(bus.rd));
    endtask

    task automatic irq_chk(input logic exp, input string name);
        expect_val(name, W'(exp));
        check_next(W'(irq));
    endtask

    task automatic gpo_chk(input logic [W-1:0] exp, input string name);
        expect_val(name, exp);
        check_next(gpo);
    endtask

    initial begin
        // Each record shows rd/gpo before its own write edge
        vecs[0]  = '{4'd1,  1'b1, 32'hDEADBEEF, 32'h0,        {32'h0, 32'h0,        32'h0}};
        vecs[1]  = '{4'd6,  1'b1, 32'h0000FFFF, 32'h0,        {32'h0, 32'h0,        32'hDEADBEEF}};
        vecs[2]  = '{4'd1,  1'b0, 32'h0,        32'hDEADBEEF, {32'h0, 32'h0,        32'hDEADBEEF}};
        vecs[3]  = '{4'd6,  1'b0, 32'h0,        32'h0000FFFF, {32'h0, 32'h0,        32'hDEADBEEF}};
        vecs[4]  = '{4'd0,  1'b1, 32'h12345678, 32'h0,        {32'h0, 32'h0,        32'hDEADBEEF}};
        vecs[5]  = '{4'd0,  1'b0, 32'h0,        32'h0,        {32'h0, 32'h0,        32'hDEADBEEF}};
        vecs[6]  = '{4'd12, 1'b1, 32'hFFFFFFFF, 32'h0,        {32'h0, 32'h0,        32'hDEADBEEF}};
        vecs[7]  = '{4'd12, 1'b0, 32'h0,        32'h0,        {32'h0, 32'h0,        32'hDEADBEEF}};
        vecs[8]  = '{4'd15, 1'b0, 32'h0,        32'h0,        {32'h0, 32'h0,        32'hDEADBEEF}};
        vecs[9]  = '{4'd5,  1'b1, 32'hA5A5A5A5, 32'h0,        {32'h0, 32'h0,        32'hDEADBEEF}};
        vecs[10] = '{4'd5,  1'b0, 32'h0,        32'hA5A5A5A5, {32'h0, 32'hA5A5A5A5, 32'hDEADBEEF}};
        vecs[11] = '{4'd9,  1'b1, 32'h00000001, 32'h0,        {32'h0, 32'hA5A5A5A5, 32'hDEADBEEF}};
        vecs[12] = '{4'd9,  1'b0, 32'h0,        32'h00000001, {32'h1, 32'hA5A5A5A5, 32'hDEADBEEF}};

        rst    = 1'b0;
        gpi    = '1;
        bus.a  = '0;
        bus.we = 1'b0;
        bus.wd = '0;

        // Reset with inputs high, then release with EN=0
        repeat (3) tick();
        gpo_chk('0, "reset_gpo");
        irq_chk(1'b0, "reset_irq");
        read_chk(0, 32'h0, "reset_gpi0");
        @(negedge clk);
        rst = 1'b1;
        repeat (4) tick();
        read_chk(0,  32'hFFFFFFFF, "rel_gpi0");
        read_chk(3,  32'h0, "rel_status0");
        read_chk(7,  32'h0, "rel_status1");
        read_chk(11, 32'h0, "rel_status2");
        read_chk(12, 32'h0, "unmapped12");
        read_chk(15, 32'h0, "unmapped15");
        irq_chk(1'b0, "rel_irq");
        gpi = '0;
        repeat (4) tick();

        // Table-driven register access
        for (int i = 0; i < 13; i++) begin
            bus.a  = vecs[i].a;
            bus.we = vecs[i].we;
            bus.wd = vecs[i].wd;
            expect_val($sformatf("vec%0d_rd", i), W'(vecs[i].rd));
            expect_val($sformatf("vec%0d_gpo", i), vecs[i].gpo);
            #1;
            check_next(W'(bus.rd));
            check_next(gpo);
            tick();
            bus.we = 1'b0;
        end

        // Rising edge on bit0 with EN0=1
        wr(2, 32'h1);
        gpi[0] = 1'b1;
        tick();
        tick();
        read_chk(0, 32'h1, "edge_gpi_k1");
        read_chk(3, 32'h0, "edge_status_k1");
        irq_chk(1'b0, "edge_irq_k1");
        tick();
        read_chk(3, 32'h1, "edge_status_k2");
        irq_chk(1'b1, "edge_irq_k2");
        wr(3, 32'h1);
        read_chk(3, 32'h0, "w1c_status");
        irq_chk(1'b0, "w1c_irq");

        // Falling edge sets nothing
        gpi[0] = 1'b0;
        repeat (4) tick();
        read_chk(3, 32'h0, "fall_status");
        irq_chk(1'b0, "fall_irq");

        // W1C colliding with a fresh rise on bit0
        wr(2, 32'h3);
        gpi[1:0] = 2'b11;
        repeat (3) tick();
        read_chk(3, 32'h3, "coll_pre_status");
        gpi[0] = 1'b0;
        repeat (3) tick();
        gpi[0] = 1'b1;
        tick();
        tick();
        wr(3, 32'h3);
        read_chk(3, 32'h1, "coll_status");
        irq_chk(1'b1, "coll_irq");
        wr(3, 32'h1);
        read_chk(3, 32'h0, "coll_clr_status");
        irq_chk(1'b0, "coll_clr_irq");

        // Clearing EN masks irq but keeps STATUS
        wr(6, 32'h80);
        gpi[39] = 1'b1;
        repeat (3) tick();
        read_chk(7, 32'h80, "mask_pre_status");
        irq_chk(1'b1, "mask_pre_irq");
        wr(6, 32'h0);
        irq_chk(1'b0, "mask_irq");
        read_chk(7, 32'h80, "mask_status");
        read_chk(6, 32'h0, "mask_en");

        // Asynchronous reset between edges
        gpi = '0;
        repeat (3) tick();
        wr(6, 32'h80);
        irq_chk(1'b1, "pre_rst_irq");
        gpo_chk({32'h1, 32'hA5A5A5A5, 32'hDEADBEEF}, "pre_rst_gpo");
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        gpo_chk('0, "async_rst_gpo");
        irq_chk(1'b0, "async_rst_irq");
        @(negedge clk);
        rst = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            read_chk(i, 32'h0, $sformatf("post_rst_idx%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
